// File: rtl/eq_fir_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | eq_fir_sched: buffer pointer / coefficient index sequencer for one FIR   |
// | channel pair. Optional overrun flag: EQ_SCHED_OVERRUN_EN.                |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module eq_fir_sched #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10,
  parameter int TAPS   = 1021
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wrt_smpl,
  output logic              wrt_en,
  output logic [ADDR_W-1:0] wrt_addr,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [ADDR_W-1:0] coeff_addr,
  output logic              sequencing,
  output logic              acc_clr,
  output logic              acc_en,
  output logic              result_vld,
`ifdef EQ_SCHED_OVERRUN_EN
  output logic              full,
  output logic              overrun
`else
  output logic              full
`endif
);

  localparam int                FILL_W    = $clog2(TAPS + 1);
  localparam logic [FILL_W-1:0] FILL_MAX  = FILL_W'(TAPS);
  localparam logic [FILL_W-1:0] FILL_TRIG = FILL_W'(TAPS - 1);
  localparam logic [ADDR_W-1:0] LAST_K    = ADDR_W'(TAPS - 1);
  localparam logic [ADDR_W-1:0] LAST_PTR  = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [ADDR_W-1:0]  new_ptr;
  logic [ADDR_W-1:0]  rd_ptr;
  logic [ADDR_W-1:0]  k;
  logic [FILL_W-1:0]  fill;
  logic               accept;
  logic               pass_start;
  logic               last_issue;

  always_comb begin
    accept     = wrt_smpl && (state == IDLE);
    pass_start = accept && (fill >= FILL_TRIG);
    last_issue = (state == RUN) && (k == LAST_K);
    state_nxt  = state;
    case (state)
      IDLE:    if (pass_start) state_nxt = RUN;
      RUN:     if (last_issue) state_nxt = DRAIN;
      DRAIN:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Write side: pointer wraps at DEPTH, fill saturates at TAPS.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      new_ptr <= '0;
      fill    <= '0;
      full    <= 1'b0;
    end else if (accept) begin
      new_ptr <= (new_ptr == LAST_PTR) ? '0 : new_ptr + 1'b1;
      if (fill != FILL_MAX) begin
        fill <= fill + 1'b1;
        full <= (fill == FILL_TRIG);
      end
    end
  end

  // Read side stops advancing on the final issue so idle outputs keep the
  // last address presented to the RAM/ROM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      k      <= '0;
    end else if (pass_start) begin
      rd_ptr <= new_ptr - LAST_K;
      k      <= '0;
    end else if ((state == RUN) && !last_issue) begin
      rd_ptr <= rd_ptr + 1'b1;
      k      <= k + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_en  <= 1'b0;
      acc_clr <= 1'b0;
    end else begin
      acc_en  <= (state == RUN);
      acc_clr <= (state == RUN) && (k == '0);
    end
  end

`ifdef EQ_SCHED_OVERRUN_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              overrun <= 1'b0;
    else if (wrt_smpl && (state != IDLE)) overrun <= 1'b1;
  end
`endif

  assign wrt_en     = accept;
  assign wrt_addr   = new_ptr;
  assign rd_addr    = rd_ptr;
  assign coeff_addr = k;
  assign sequencing = (state == RUN);
  assign result_vld = (state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_eq_fir_sched.sv
`default_nettype none
// Self-checking bench for eq_fir_sched (DEPTH=8, TAPS=5) against a
// cycle-timeline reference model built from the write-address history.
module tb_eq_fir_sched;

  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;
  localparam int TAPS   = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              wrt_smpl;
  logic              wrt_en;
  logic [ADDR_W-1:0] wrt_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] coeff_addr;
  logic              sequencing;
  logic              acc_clr;
  logic              acc_en;
  logic              result_vld;
  logic              full;
`ifdef EQ_SCHED_OVERRUN_EN
  logic              overrun;
`endif

  eq_fir_sched #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .TAPS(TAPS)) dut (
    .clk        (clk),
    .rst        (rst),
    .wrt_smpl   (wrt_smpl),
    .wrt_en     (wrt_en),
    .wrt_addr   (wrt_addr),
    .rd_addr    (rd_addr),
    .coeff_addr (coeff_addr),
    .sequencing (sequencing),
    .acc_clr    (acc_clr),
    .acc_en     (acc_en),
    .result_vld (result_vld),
`ifdef EQ_SCHED_OVERRUN_EN
    .full       (full),
    .overrun    (overrun)
`else
    .full       (full)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  // Reference state: samples accepted since reset, position within a pass
  // (0 = no pass, 1..TAPS+2 = cycle index after the triggering write).
  int         wcount;
  int         pc;
  bit         ovr_exp;
  logic [2:0] hist[$];
  logic [2:0] pass_addr[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    wcount  = 0;
    pc      = 0;
    ovr_exp = 0;
    hist.delete();
    pass_addr.delete();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ":wrt_en"}, wrt_en, 0);
    chk({tag, ":wrt_addr"}, wrt_addr, 0);
    chk({tag, ":rd_addr"}, rd_addr, 0);
    chk({tag, ":coeff_addr"}, coeff_addr, 0);
    chk({tag, ":full"}, full, 0);
    chk({tag, ":sequencing"}, sequencing, 0);
    chk({tag, ":acc_clr"}, acc_clr, 0);
    chk({tag, ":acc_en"}, acc_en, 0);
    chk({tag, ":result_vld"}, result_vld, 0);
`ifdef EQ_SCHED_OVERRUN_EN
    chk({tag, ":overrun"}, overrun, 0);
`endif
  endtask

  // One clock cycle: drive, check mid-cycle, advance the model, step past the edge.
  task automatic cycle(input bit smpl);
    bit acc;
    int fill_now;
    wrt_smpl = smpl;
    @(negedge clk);
    fill_now = (wcount < TAPS) ? wcount : TAPS;
    acc = smpl && (pc == 0);
    chk("wrt_en", wrt_en, acc);
    chk("wrt_addr", wrt_addr, wcount % DEPTH);
    chk("full", full, fill_now == TAPS);
    chk("sequencing", sequencing, (pc >= 1) && (pc <= TAPS));
    chk("acc_en", acc_en, (pc >= 2) && (pc <= TAPS + 1));
    chk("acc_clr", acc_clr, pc == 2);
    chk("result_vld", result_vld, pc == TAPS + 2);
    if ((pc >= 1) && (pc <= TAPS)) begin
      chk("rd_addr", rd_addr, pass_addr[pc-1]);
      chk("coeff_addr", coeff_addr, pc - 1);
    end
`ifdef EQ_SCHED_OVERRUN_EN
    chk("overrun", overrun, ovr_exp);
`endif
    if (smpl && (pc != 0)) ovr_exp = 1;
    if (pc != 0) begin
      pc = (pc == TAPS + 2) ? 0 : pc + 1;
    end else if (acc) begin
      hist.push_back(3'(wcount % DEPTH));
      if (hist.size() > TAPS) void'(hist.pop_front());
      if (fill_now >= TAPS - 1) begin
        pc        = 1;
        pass_addr = hist;
      end
      wcount++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0);
  endtask

  initial begin
    rst      = 1'b1;
    wrt_smpl = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b0;

    // Fill phase: four samples, no pass.
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1);
      idle(2);
    end
    // Fifth sample triggers the first pass.
    cycle(1'b1);
    idle(8);
    // Samples 6..10 at minimum spacing; the 10th wraps the write pointer.
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1);
      idle(TAPS + 2);
    end
    chk("wcount_after_ten", wrt_addr, 2);

    // Dropped sample in cycle 3 of a pass.
    cycle(1'b1);
    idle(2);
    cycle(1'b1);
    idle(6);

    // Pulses in DONE and the following IDLE cycle.
    cycle(1'b1);
    idle(TAPS + 1);
    cycle(1'b1);
    cycle(1'b1);
    idle(TAPS + 4);

    // Asynchronous reset in cycle 3 of a pass.
    cycle(1'b1);
    idle(2);
    rst      = 1'b1;
    wrt_smpl = 1'b0;
    #1;
    chk_zero("mid_reset");
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(3);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1);
      idle(2);
    end
    cycle(1'b1);
    idle(8);

    // Random traffic, including drops during passes.
    for (int i = 0; i < 400; i++) cycle($urandom_range(0, 3) == 0);
    idle(10);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/eq_fir_sched.md
# eq_fir_sched

- Sequencing controller for one equalizer FIR channel pair: owns the circular sample buffer pointers and the coefficient index, and drives the shared multiply-accumulate enables.
- Each accepted audio sample is written into the buffer. Once the buffer holds TAPS samples, every new sample triggers one convolution pass: TAPS read addresses from oldest to newest, with matching coefficient addresses, then a result strobe.
- Sits between the codec sample-valid strobe and the band FIR datapath/RAMs.
- One instance serves both the left and right buffers, which share addresses.

## Interface
Parameters:
- DEPTH, 1024 — buffer entries; power of two.
- ADDR_W, 10 — log2(DEPTH).
- TAPS, 1021 — taps per pass; 2 ≤ TAPS ≤ DEPTH-1.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  asynchronous, active-high reset.
- wrt_smpl  in  1  one-cycle pulse: new sample present on datapath.
- wrt_en  out  1  buffer write enable.
- wrt_addr  out  ADDR_W  buffer write address.
- rd_addr  out  ADDR_W  buffer read address.
- coeff_addr  out  ADDR_W  coefficient ROM address.
- sequencing  out  1  high while read addresses are being issued.
- acc_clr  out  1  accumulator loads the product instead of adding it.
- acc_en  out  1  accumulator update enable.
- result_vld  out  1  one-cycle pulse: accumulator holds the finished sum.
- full  out  1  TAPS samples are resident.
- overrun  out  1  sticky flag; present only with EQ_SCHED_OVERRUN_EN (see Configuration).

## Operation
- Registers:
  - new_ptr: next write slot.
  - fill: saturating count, 0..TAPS.
  - rd_ptr and k: pass index.
  - State: IDLE, RUN, DRAIN, DONE.
- Write acceptance:
  - wrt_en = wrt_smpl & (state == IDLE); combinational.
  - wrt_addr = new_ptr.
  - On accept: new_ptr <= new_ptr+1 mod DEPTH; fill <= min(fill+1, TAPS).
- full = (fill == TAPS); it is registered, so it reflects writes completed in prior cycles.
- Pass start: an accept when fill ≥ TAPS-1 (the write makes the buffer full) moves IDLE→RUN.
  - rd_ptr <= new_ptr - (TAPS-1) mod DEPTH; this addresses the oldest sample, and the last read is the just-written sample.
  - k <= 0.
- An accept while not yet full writes only and stays in IDLE.
- RUN:
  - rd_addr = rd_ptr, coeff_addr = k, sequencing = 1.
  - Each cycle rd_ptr wraps mod DEPTH and k++.
  - After k == TAPS-1 is issued → DRAIN.
- DRAIN: one cycle; covers the 1-cycle RAM/ROM read latency.
- DONE: result_vld = 1 for one cycle → IDLE.
- Accumulator control is the RUN address stream delayed by one cycle:
  - acc_en is high exactly TAPS cycles.
  - acc_clr is high on the first of those cycles only.
- wrt_smpl while not IDLE: not accepted; no pointer or fill change.
- Idle outputs: rd_addr and coeff_addr hold their last values; sequencing, acc_en, acc_clr and result_vld are 0.
- Reset, asynchronous and at any time including mid-pass:
  - Registers: new_ptr=0, fill=0, rd_ptr=0, k=0, state=IDLE.
  - Outputs: wrt_addr=0, rd_addr=0, coeff_addr=0; full, sequencing, acc_clr, acc_en, result_vld and overrun all 0.
  - An in-flight pass is abandoned with no result_vld, and a refill of TAPS samples is needed.

## Timing
- Cycle 0: wrt_smpl accepted (wrt_en=1), and this write makes the buffer full.
- Cycles 1..TAPS: RUN.
- Cycles 2..TAPS+1: acc_en=1; acc_clr=1 in cycle 2.
- Cycle TAPS+1: DRAIN. Cycle TAPS+2: result_vld.
- Earliest next accept: cycle TAPS+3. Minimum sample spacing is TAPS+3 cycles.
- Latency from the accepting write to result_vld: TAPS+2 cycles.
- Default TAPS=1021: 1023 cycles, well below the sample period at the system clock.

## Configuration
- Macro EQ_SCHED_OVERRUN_EN.
- Defined:
  - overrun port exists.
  - overrun is set on any wrt_smpl that arrives while state != IDLE.
  - It stays set until rst.
- Undefined: no overrun port; a dropped sample is silent.
- All other behaviour is identical in both builds.

## Test plan
All scenarios use DEPTH=8, ADDR_W=3, TAPS=5.
- Reset, then 4 wrt_smpl pulses spaced 3 cycles apart → wrt_addr 0,1,2,3; full=0; sequencing never asserted.
- 5th pulse → wrt_addr=4; then rd_addr 0,1,2,3,4 and coeff_addr 0..4 over cycles 1–5; acc_en cycles 2–6 with acc_clr in cycle 2; result_vld in cycle 7; full=1.
- Continue to the 10th sample (wrt_addr=1, wrapped) → rd_addr 5,6,7,0,1.
- wrt_smpl in cycle 3 of a pass → no write and pointers unchanged; with EQ_SCHED_OVERRUN_EN, overrun=1 and stays set.
- Assert rst in cycle 3 of a pass → all outputs 0 immediately; no result_vld; the next 4 samples do not start a pass.
- Pulse wrt_smpl in DONE and then the following cycle → first dropped, second accepted in IDLE.
